// File: rtl/spi_command_decoder.sv
// spi_command_decoder: SPI mode-0 slave that decodes note/tuning frames into voice strobes and held fields.
// Define SPI_READBACK_EN to shift {1'b0, o_error_count} out on o_spi_miso during the command byte.
module spi_command_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_VOICES  = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_spi_sck,
  input  logic        i_spi_mosi,
  input  logic        i_spi_cs_n,
  output logic        o_spi_miso,
  output logic        o_SPI_note_status,
  output logic [7:0]  o_SPI_voice_index,
  output logic [31:0] o_SPI_tuning_code,
  output logic [6:0]  o_SPI_velocity,
  output logic        o_SPI_flag_dds,
  output logic        o_SPI_flag_adsr,
  output logic        o_frame_error,
  output logic [6:0]  o_error_count
);
  typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, COMMIT, DISCARD} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_cs_sync;
  logic r_sck_d;
  logic [2:0] r_bit_cnt, r_byte_cnt;
  logic [6:0] r_shift;
  logic [1:0] r_op;
  logic [7:0] r_sh_voice, r_voice_index;
  logic [6:0] r_sh_vel, r_velocity, r_error_count;
  logic [31:0] r_sh_tune, r_tuning_code;
  logic r_note_status, r_flag_dds, r_flag_adsr, r_frame_error;
  logic w_sck, w_mosi, w_cs_n, w_rise, w_shift_en, w_byte_done, w_cmd_done, w_pl_done;
  logic w_voice_bad, w_commit, w_err;
  logic [7:0] w_byte, w_voice_nxt;
  logic [6:0] w_vel_nxt;
  logic [31:0] w_tune_nxt;
  logic [2:0] w_last_idx;
  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_rise      = w_sck & ~r_sck_d;
  assign w_shift_en  = w_rise & ~w_cs_n & (r_state == CMD || r_state == PAYLOAD);
  assign w_byte      = {r_shift, w_mosi};
  assign w_byte_done = w_shift_en & (r_bit_cnt == 3'd7);
  assign w_cmd_done  = w_byte_done & (r_state == CMD);
  assign w_pl_done   = w_byte_done & (r_state == PAYLOAD);
  assign w_voice_bad = 32'(w_byte) >= 32'(NUM_VOICES);
  assign w_last_idx  = (r_op == 2'd1) ? 3'd6 : (r_op == 2'd2) ? 3'd1 : 3'd5;
  // Tuning bytes are every payload byte from index 2 on, except the NOTE_ON velocity byte
  assign w_voice_nxt = (w_pl_done && r_byte_cnt == 3'd1) ? w_byte : r_sh_voice;
  assign w_vel_nxt   = (w_pl_done && r_op == 2'd1 && r_byte_cnt == 3'd2) ? w_byte[6:0] : r_sh_vel;
  assign w_tune_nxt  = (w_pl_done && r_byte_cnt >= 3'd2 && !(r_op == 2'd1 && r_byte_cnt == 3'd2))
                       ? {r_sh_tune[23:0], w_byte} : r_sh_tune;
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE:    w_next = w_cs_n ? IDLE : CMD;
      CMD:
        if (w_cs_n) w_next = IDLE;
        else if (w_byte_done) begin
          w_err  = !(w_byte inside {8'h01, 8'h02, 8'h03});
          w_next = w_err ? DISCARD : PAYLOAD;
        end
      PAYLOAD:
        if (w_cs_n) w_next = IDLE;
        else if (w_byte_done) begin
          w_err    = (r_byte_cnt == 3'd1) && w_voice_bad;
          w_commit = !w_err && (r_byte_cnt == w_last_idx);
          w_next   = w_err ? DISCARD : w_commit ? COMMIT : PAYLOAD;
        end
      COMMIT:  w_next = DISCARD;
      default: w_next = w_cs_n ? IDLE : DISCARD;
    endcase
  end
  // CS_n sync resets to "low" so DISCARD waits for the real pin to be seen high
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '0;
      r_sck_d     <= 1'b0;
      r_state     <= DISCARD;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_op        <= '0;
      r_sh_voice  <= '0;
      r_sh_vel    <= '0;
      r_sh_tune   <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      r_sck_d     <= w_sck;
      r_state     <= w_next;
      r_bit_cnt   <= (r_state == IDLE) ? 3'd0 : w_shift_en ? r_bit_cnt + 3'd1 : r_bit_cnt;
      r_byte_cnt  <= (r_state == IDLE) ? 3'd0 : w_byte_done ? r_byte_cnt + 3'd1 : r_byte_cnt;
      if (w_shift_en) r_shift <= w_byte[6:0];
      if (w_cmd_done) r_op <= w_byte[1:0];
      r_sh_voice  <= w_voice_nxt;
      r_sh_vel    <= w_vel_nxt;
      r_sh_tune   <= w_tune_nxt;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_note_status <= 1'b0;
      r_voice_index <= '0;
      r_tuning_code <= '0;
      r_velocity    <= '0;
      r_flag_dds    <= 1'b0;
      r_flag_adsr   <= 1'b0;
      r_frame_error <= 1'b0;
      r_error_count <= '0;
    end else begin
      r_flag_dds    <= w_commit & (r_op != 2'd2);
      r_flag_adsr   <= w_commit & (r_op != 2'd3);
      r_frame_error <= w_err;
      r_error_count <= r_error_count + {6'd0, w_err && r_error_count != 7'h7f};
      if (w_commit) begin
        r_voice_index <= w_voice_nxt;
        if (r_op != 2'd3) r_note_status <= (r_op == 2'd1);
        if (r_op == 2'd1) r_velocity <= w_vel_nxt;
        if (r_op != 2'd2) r_tuning_code <= w_tune_nxt;
      end
    end
  end
`ifdef SPI_READBACK_EN
  logic [7:0] r_miso_sr;
  logic w_fall;
  assign w_fall = ~w_sck & r_sck_d;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_miso_sr <= '0;
    else if (r_state == IDLE && !w_cs_n) r_miso_sr <= {1'b0, r_error_count};
    else if (r_state == CMD && w_fall) r_miso_sr <= {r_miso_sr[6:0], 1'b0};
  end
  assign o_spi_miso = (r_state == CMD) & r_miso_sr[7];
`else
  assign o_spi_miso = 1'b0;
`endif
  assign o_SPI_note_status = r_note_status;
  assign o_SPI_voice_index = r_voice_index;
  assign o_SPI_tuning_code = r_tuning_code;
  assign o_SPI_velocity    = r_velocity;
  assign o_SPI_flag_dds    = r_flag_dds;
  assign o_SPI_flag_adsr   = r_flag_adsr;
  assign o_frame_error     = r_frame_error;
  assign o_error_count     = r_error_count;
endmodule

// File: tb/tb_spi_command_decoder.sv
// tb_spi_command_decoder: directed and random SPI frames checked against a frame-level reference model.
module tb_spi_command_decoder;
  localparam int NV = 64;
  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0, cs_n = 1'b1;
  logic miso, st, dds, adsr, ferr;
  logic [7:0] voice;
  logic [31:0] tune;
  logic [6:0] vel, ecnt;
  int errors = 0, checks = 0;
  int n_dds, n_adsr, n_err;
  time t_rise = 0;
  logic m_st = 1'b0, m_discard = 1'b0;
  logic [7:0] m_voice = '0;
  logic [31:0] m_tune = '0;
  logic [6:0] m_vel = '0, m_ecnt = '0;
  logic [7:0] fq [9];
  always #5 clk = ~clk;
  spi_command_decoder #(.SYNC_STAGES(2), .NUM_VOICES(NV)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_spi_sck(sck), .i_spi_mosi(mosi), .i_spi_cs_n(cs_n),
    .o_spi_miso(miso), .o_SPI_note_status(st), .o_SPI_voice_index(voice),
    .o_SPI_tuning_code(tune), .o_SPI_velocity(vel), .o_SPI_flag_dds(dds),
    .o_SPI_flag_adsr(adsr), .o_frame_error(ferr), .o_error_count(ecnt)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // 2 sync stages + edge-detect cycle + commit cycle after the final SCK rise (rise driven on a falling clk edge)
  always @(negedge clk) begin
    if (dds) n_dds++;
    if (adsr) n_adsr++;
    if (ferr) n_err++;
    if (dds | adsr | ferr) check("strobe_latency", $time - t_rise, 64'd30);
  end
  task automatic send_byte(input logic [7:0] b, input logic [7:0] rb);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      sck  = 1'b0;
      repeat (4) @(negedge clk);
      check("miso", miso, rb[i]);
      sck    = 1'b1;
      t_rise = $time;
      repeat (4) @(negedge clk);
    end
    sck = 1'b0;
  endtask
  task automatic run_frame(input int n);
    logic [7:0] rb, op;
    int len, e_dds, e_adsr, e_err;
    rb = 8'h00;
`ifdef SPI_READBACK_EN
    if (!m_discard) rb = {1'b0, m_ecnt};
`endif
    n_dds = 0; n_adsr = 0; n_err = 0;
    e_dds = 0; e_adsr = 0; e_err = 0;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < n; k++) send_byte(fq[k], (k == 0) ? rb : 8'h00);
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    if (!m_discard && n >= 1) begin
      op  = fq[0];
      len = (op == 8'h01) ? 7 : (op == 8'h02) ? 2 : (op == 8'h03) ? 6 : 0;
      if (len == 0) e_err = 1;
      else if (n >= 2 && int'(fq[1]) >= NV) e_err = 1;
      else if (n >= len) begin
        m_voice = fq[1];
        if (op == 8'h01) begin
          m_st = 1'b1; m_vel = fq[2][6:0]; m_tune = {fq[3], fq[4], fq[5], fq[6]};
          e_dds = 1; e_adsr = 1;
        end else if (op == 8'h02) begin
          m_st = 1'b0; e_adsr = 1;
        end else begin
          m_tune = {fq[2], fq[3], fq[4], fq[5]}; e_dds = 1;
        end
      end
    end
    if (e_err == 1 && m_ecnt != 7'h7f) m_ecnt++;
    m_discard = 1'b0;
    check("n_dds", 64'(n_dds), 64'(e_dds));
    check("n_adsr", 64'(n_adsr), 64'(e_adsr));
    check("n_err", 64'(n_err), 64'(e_err));
    check("note_status", st, m_st);
    check("voice", voice, m_voice);
    check("tuning", tune, m_tune);
    check("velocity", vel, m_vel);
    check("error_count", ecnt, m_ecnt);
  endtask
  task automatic set_frame(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    fq[0] = b0; fq[1] = b1; fq[2] = b2; fq[3] = b3; fq[4] = b4; fq[5] = b5; fq[6] = b6;
    fq[7] = 8'($urandom); fq[8] = 8'($urandom);
  endtask
  task automatic check_reset_state();
    check("rst_status", st, 1'b0);
    check("rst_voice", voice, 8'h00);
    check("rst_tuning", tune, 32'h0);
    check("rst_velocity", vel, 7'h00);
    check("rst_strobes", {dds, adsr, ferr, miso}, 4'h0);
    check("rst_errcnt", ecnt, 7'h00);
  endtask
  initial begin
    int r, n, len;
    logic [7:0] op;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    set_frame(8'h01, 8'h05, 8'h64, 8'h00, 8'h12, 8'h34, 8'h56);
    run_frame(7);
    set_frame(8'h02, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE);
    run_frame(2);
    set_frame(8'h7F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    run_frame(6);
    set_frame(8'h03, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00);
    run_frame(6);
    set_frame(8'h01, 8'h07, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44);
    run_frame(3);
    run_frame(7);
    set_frame(8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_frame(2);
    set_frame(8'h01, 8'h3F, 8'h7E, 8'hCA, 8'hFE, 8'hBA, 8'hBE);
    run_frame(9);
    // Reset mid-frame with CS_n held low; the rest of the frame must be ignored
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h01, 8'h00);
    send_byte(8'h09, 8'h00);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    m_st = 1'b0; m_voice = '0; m_tune = '0; m_vel = '0; m_ecnt = '0; m_discard = 1'b1;
    set_frame(8'h01, 8'h09, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04);
    run_frame(7);
    set_frame(8'h03, 8'h0A, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00);
    run_frame(6);
    for (int i = 0; i < 3; i++) begin
      set_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(1);
    end
    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 3) ? 8'h01 : (r < 5) ? 8'h02 : (r < 7) ? 8'h03 : 8'($urandom);
      set_frame(op, 8'($urandom_range(0, NV + 15)), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom));
      len = (op == 8'h01) ? 7 : (op == 8'h02) ? 2 : (op == 8'h03) ? 6 : int'($urandom_range(1, 6));
      n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : len + int'($urandom_range(0, 2));
      run_frame(n);
    end
    for (int i = 0; i < 130; i++) begin
      op = 8'($urandom_range(4, 255));
      set_frame(op, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(1);
    end
    check("saturated", ecnt, 7'h7f);
    set_frame(8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_frame(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
